// File: rtl/seq_rightshift_pkg.sv
// Shared ALU shifter definitions: FSM state encoding, shift-mode constants
// and the default datapath geometry used by seq_rightshift.
package seq_rightshift_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic SHIFT_SRL = 1'b0;
    localparam logic SHIFT_SRA = 1'b1;

endpackage

// File: rtl/seq_rightshift_stage.sv
// rshift_stage: one conditional stage of a log right shifter.
//   data  : word to shift
//   en    : 1 = shift right by 2^stage, 0 = pass through
//   stage : stage index (shift distance is 2^stage)
//   fill  : value for vacated MSBs
//   y     : shifted word
module rshift_stage #(
    parameter int WIDTH = 32,
    parameter int STG_W = 3
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [STG_W-1:0] stage,
    input  logic             fill,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = data >> (1 << stage);
        // ones over the vacated top bits
        mask    = ~({WIDTH{1'b1}} >> (1 << stage));
        y       = en ? (shifted | ({WIDTH{fill}} & mask)) : data;
    end

endmodule

// File: rtl/seq_rightshift.sv
// seq_rightshift: multi-cycle SRL/SRA, one log-shifter stage per clock.
//   clk, rst_n : clock, async active-low reset
//   start      : request, accepted in IDLE or DONE
//   arith      : 1 = SRA, 0 = SRL (latched with start)
//   a, b       : operand and full-width shift amount (latched with start)
//   busy       : high while shifting
//   done       : one-cycle result-valid pulse
//   s          : result, held until the next result is produced
module seq_rightshift
    import seq_rightshift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s
);

    localparam int STG_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [SHAMT_W-1:0] amt_q,   amt_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic               mode_q,  mode_d;
    logic               ovf_q,   ovf_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [WIDTH-1:0]   s_q,     s_d;

    logic [WIDTH-1:0]   stage_y;
    logic [WIDTH-1:0]   ovf_val;
    logic               fill;

    // With SRA the MSB never changes while shifting (fill is the MSB),
    // so data_q[WIDTH-1] is the original sign in every stage.
    assign fill    = (mode_q == SHIFT_SRA) & data_q[WIDTH-1];
    assign ovf_val = (mode_q == SHIFT_SRA) ? {WIDTH{data_q[WIDTH-1]}} : '0;

    // amt_q is shifted down each stage, so bit 0 always belongs to stage_q.
    rshift_stage #(.WIDTH(WIDTH), .STG_W(STG_W)) u_stage (
        .data  (data_q),
        .en    (amt_q[0]),
        .stage (stage_q),
        .fill  (fill),
        .y     (stage_y)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        stage_d = stage_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s_d     = s_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (start) begin
                    data_d  = a;
                    amt_d   = b[SHAMT_W-1:0];
                    mode_d  = arith;
                    ovf_d   = |b[WIDTH-1:SHAMT_W];
                    stage_d = '0;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                data_d  = stage_y;
                amt_d   = amt_q >> 1;
                stage_d = stage_q + 1'b1;
                // fixed latency: all stages run even for zero/overflow amounts
                if (stage_q == STG_W'(SHAMT_W-1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    s_d     = ovf_q ? ovf_val : stage_y;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            stage_q <= '0;
            mode_q  <= SHIFT_SRL;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            stage_q <= stage_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;

endmodule
